// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths and types for the 16-bit pipeline ID/EX
//                operand forwarding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int         DATA_W   = 16;
    localparam int         ADDR_W   = 4;
    localparam logic [3:0] REG_ZERO = 4'h0;

    // Source of an operand leaving the forwarding mux.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RF   = 2'd1,
        SEL_MEM  = 2'd2,
        SEL_EX   = 2'd3
    } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Per-source forwarding: matches one source register against
//                the EX and MEM writers and picks EX result, MEM result or
//                register-file data. Also flags a load still sitting in EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_ex_vld,
    input  logic              i_ex_we,
    input  logic              i_ex_ld,
    input  logic [ADDR_W-1:0] i_ex_dst_addr,
    input  logic [DATA_W-1:0] i_ex_rslt,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_dst_addr,
    input  logic [DATA_W-1:0] i_mem_rslt,
    output logic [DATA_W-1:0] o_operand,
    output logic              o_ld_hazard
);

    import cpu_pkg::*;

    logic     w_src_live;
    logic     w_ex_match;
    logic     w_mem_match;
    fwd_sel_e w_sel;

    // R0 is hard-wired to zero, so it never takes a forwarded value.
    assign w_src_live  = i_re && (i_src_addr != ADDR_W'(REG_ZERO));
    assign w_ex_match  = w_src_live && i_ex_vld && i_ex_we && (i_ex_dst_addr == i_src_addr);
    assign w_mem_match = w_src_live && i_mem_we && (i_mem_dst_addr == i_src_addr);

    // A load in EX has no data yet; the top stalls on this.
    assign o_ld_hazard = w_ex_match && i_ex_ld;

    // Youngest writer wins: EX ahead of MEM, MEM ahead of the register file.
    always_comb begin
        w_sel = SEL_RF;
        if (!i_re) begin
            w_sel = SEL_ZERO;
        end else if (w_ex_match && !i_ex_ld) begin
            w_sel = SEL_EX;
        end else if (w_mem_match) begin
            w_sel = SEL_MEM;
        end
    end

    // Drive the operand from the selected source.
    always_comb begin
        o_operand = '0;
        case (w_sel)
            SEL_EX:   o_operand = i_ex_rslt;
            SEL_MEM:  o_operand = i_mem_rslt;
            SEL_RF:   o_operand = i_rf_data;
            default:  o_operand = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/operand_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fwd_stage
//  Description : ID/EX boundary. Forwards EX/MEM results into the two source
//                operands, stalls ID for one cycle on a load-use hazard,
//                kills ID on flush, and carries EX/MEM destination tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_vld,
    input  logic [ADDR_W-1:0] id_p0_addr,
    input  logic [ADDR_W-1:0] id_p1_addr,
    input  logic              id_re0,
    input  logic              id_re1,
    input  logic [ADDR_W-1:0] id_dst_addr,
    input  logic              id_we,
    input  logic              id_ld,
    input  logic [DATA_W-1:0] rf_p0,
    input  logic [DATA_W-1:0] rf_p1,
    input  logic [DATA_W-1:0] ex_rslt,
    input  logic [DATA_W-1:0] mem_rslt,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_vld,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [ADDR_W-1:0] ex_dst_addr,
    output logic              ex_we,
    output logic              ex_ld,
    output logic [ADDR_W-1:0] mem_dst_addr,
    output logic              mem_we,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // EX / MEM pipe state
    logic              r_ex_vld;
    logic              r_ex_we;
    logic              r_ex_ld;
    logic [ADDR_W-1:0] r_ex_dst;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [ADDR_W-1:0] r_mem_dst;
    logic              r_mem_we;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Per-source views (index 0 = A, 1 = B)
    logic [1:0]        w_re;
    logic [ADDR_W-1:0] w_src_addr [2];
    logic [DATA_W-1:0] w_rf_data  [2];
    logic [DATA_W-1:0] w_operand  [2];
    logic [1:0]        w_ld_hz;
    logic              w_luse;
    logic              w_kill;

    assign w_re          = {id_re1, id_re0};
    assign w_src_addr[0] = id_p0_addr;
    assign w_src_addr[1] = id_p1_addr;
    assign w_rf_data[0]  = rf_p0;
    assign w_rf_data[1]  = rf_p1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        fwd_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_fwd_mux (
            .i_re           (w_re[gi]),
            .i_src_addr     (w_src_addr[gi]),
            .i_rf_data      (w_rf_data[gi]),
            .i_ex_vld       (r_ex_vld),
            .i_ex_we        (r_ex_we),
            .i_ex_ld        (r_ex_ld),
            .i_ex_dst_addr  (r_ex_dst),
            .i_ex_rslt      (ex_rslt),
            .i_mem_we       (r_mem_we),
            .i_mem_dst_addr (r_mem_dst),
            .i_mem_rslt     (mem_rslt),
            .o_operand      (w_operand[gi]),
            .o_ld_hazard    (w_ld_hz[gi])
        );
    end

    // Flush takes precedence: a killed instruction never stalls or counts.
    assign w_luse   = id_vld && !flush && (|w_ld_hz);
    assign w_kill   = flush || w_luse;
    assign stall_id = w_luse && !rst;

    // ID/EX and EX/MEM pipe registers; a killed or stalled ID becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_vld  <= 1'b0;
            r_ex_we   <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_ex_dst  <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_mem_dst <= '0;
            r_mem_we  <= 1'b0;
        end else begin
            r_mem_dst <= r_ex_dst;
            r_mem_we  <= r_ex_we & r_ex_vld;
            if (w_kill) begin
                r_ex_vld <= 1'b0;
                r_ex_we  <= 1'b0;
                r_ex_ld  <= 1'b0;
            end else begin
                r_ex_vld <= id_vld;
                r_ex_we  <= id_we & id_vld;
                r_ex_ld  <= id_ld & id_vld;
                r_ex_dst <= id_dst_addr;
                r_op_a   <= w_operand[0];
                r_op_b   <= w_operand[1];
            end
        end
    end

    // Saturating count of load-use stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_luse && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign ex_vld       = r_ex_vld;
    assign ex_we        = r_ex_we;
    assign ex_ld        = r_ex_ld;
    assign ex_dst_addr  = r_ex_dst;
    assign ex_opA       = r_op_a;
    assign ex_opB       = r_op_b;
    assign mem_dst_addr = r_mem_dst;
    assign mem_we       = r_mem_we;
    assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fwd_stage
//  Description : Scoreboard bench for operand_fwd_stage. The driver issues
//                instructions and pushes expected EX contents; a monitor pops
//                and compares whenever ex_vld is high. The reference resolves
//                each source by searching in-flight writers youngest first.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fwd_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_vld = 1'b0;
    logic [AW-1:0] id_p0_addr = '0;
    logic [AW-1:0] id_p1_addr = '0;
    logic          id_re0 = 1'b0;
    logic          id_re1 = 1'b0;
    logic [AW-1:0] id_dst_addr = '0;
    logic          id_we = 1'b0;
    logic          id_ld = 1'b0;
    logic [DW-1:0] rf_p0 = '0;
    logic [DW-1:0] rf_p1 = '0;
    logic [DW-1:0] ex_rslt = '0;
    logic [DW-1:0] mem_rslt = '0;
    logic          flush = 1'b0;
    logic          stall_id;
    logic          ex_vld;
    logic [DW-1:0] ex_opA;
    logic [DW-1:0] ex_opB;
    logic [AW-1:0] ex_dst_addr;
    logic          ex_we;
    logic          ex_ld;
    logic [AW-1:0] mem_dst_addr;
    logic          mem_we;
    logic [CW-1:0] stall_cnt;

    operand_fwd_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_vld(id_vld),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
        .id_re0(id_re0), .id_re1(id_re1),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_ld(id_ld),
        .rf_p0(rf_p0), .rf_p1(rf_p1), .ex_rslt(ex_rslt), .mem_rslt(mem_rslt),
        .flush(flush), .stall_id(stall_id), .ex_vld(ex_vld),
        .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_dst_addr(ex_dst_addr),
        .ex_we(ex_we), .ex_ld(ex_ld), .mem_dst_addr(mem_dst_addr),
        .mem_we(mem_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          vld;
        bit [AW-1:0] a, b;
        bit          re0, re1;
        bit [AW-1:0] dst;
        bit          we, ld, flush;
        bit [DW-1:0] rf0, rf1, exr, memr;
    } stim_t;

    typedef struct {
        bit          vld, we, ld;
        bit [AW-1:0] dst;
    } slot_t;

    typedef struct {
        logic [DW-1:0] a, b;
        logic [AW-1:0] dst;
        logic          we, ld;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  q[$];
    slot_t inflight [2];            // [0] = EX (youngest), [1] = MEM
    int    m_cnt = 0;
    bit    exp_stall = 0;
    int    exp_cnt_now = 0;
    bit    exp_mem_we = 0;
    bit [AW-1:0] exp_mem_dst = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value a source sees: youngest in-flight writer of the register, else RF.
    // A load still in EX has no value yet -> hazard.
    task automatic ref_src(input bit re, input bit [AW-1:0] addr, input bit [DW-1:0] rf,
                           input bit [DW-1:0] exr, input bit [DW-1:0] memr,
                           output bit [DW-1:0] val, output bit hazard);
        bit [DW-1:0] stage_val [2];
        stage_val[0] = exr;
        stage_val[1] = memr;
        val = rf;
        hazard = 0;
        if (!re) begin
            val = '0;
        end else if (addr != 0) begin
            for (int i = 0; i < 2; i++) begin
                if (inflight[i].vld && inflight[i].we && inflight[i].dst == addr) begin
                    if (i == 0 && inflight[i].ld) hazard = 1;
                    else val = stage_val[i];
                    break;
                end
            end
        end
    endtask

    task automatic drive(input stim_t s);
        bit [DW-1:0] va, vb;
        bit ha, hb, luse, issue;
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_vld = s.vld; id_p0_addr = s.a; id_p1_addr = s.b;
        id_re0 = s.re0; id_re1 = s.re1; id_dst_addr = s.dst;
        id_we = s.we; id_ld = s.ld; flush = s.flush;
        rf_p0 = s.rf0; rf_p1 = s.rf1; ex_rslt = s.exr; mem_rslt = s.memr;
        exp_cnt_now = m_cnt;
        exp_mem_we  = inflight[1].vld && inflight[1].we;
        exp_mem_dst = inflight[1].dst;
        ref_src(s.re0, s.a, s.rf0, s.exr, s.memr, va, ha);
        ref_src(s.re1, s.b, s.rf1, s.exr, s.memr, vb, hb);
        luse  = s.vld && !s.flush && (ha || hb);
        issue = s.vld && !s.flush && !luse;
        exp_stall = luse;
        if (issue) begin
            e.a = va; e.b = vb; e.dst = s.dst; e.we = s.we; e.ld = s.ld;
            q.push_back(e);
        end
        inflight[1] = inflight[0];
        inflight[0].vld = issue;
        inflight[0].we  = issue && s.we;
        inflight[0].ld  = issue && s.ld;
        inflight[0].dst = s.dst;
        if (luse && m_cnt != int'(CNT_MAX)) m_cnt++;
    endtask

    function automatic stim_t mk(bit we, bit ld, bit [AW-1:0] dst,
                                 bit re0, bit [AW-1:0] a, bit re1, bit [AW-1:0] b);
        stim_t s;
        s.vld = 1; s.flush = 0;
        s.we = we; s.ld = ld; s.dst = dst;
        s.re0 = re0; s.a = a; s.re1 = re1; s.b = b;
        s.rf0  = (a == 0) ? '0 : 16'($urandom);
        s.rf1  = (b == 0) ? '0 : 16'($urandom);
        s.exr  = 16'($urandom);
        s.memr = 16'($urandom);
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = mk(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
               4'($urandom_range(0, 3)),
               1'($urandom_range(0, 9) < 8), 4'($urandom_range(0, 3)),
               1'($urandom_range(0, 9) < 8), 4'($urandom_range(0, 3)));
        s.vld   = ($urandom_range(0, 9) != 0);
        s.flush = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_stall_id"}, 32'(stall_id), 0);
        check({tag, "_ex_vld"}, 32'(ex_vld), 0);
        check({tag, "_ex_opA"}, 32'(ex_opA), 0);
        check({tag, "_ex_opB"}, 32'(ex_opB), 0);
        check({tag, "_ex_dst"}, 32'(ex_dst_addr), 0);
        check({tag, "_ex_we"}, 32'(ex_we), 0);
        check({tag, "_ex_ld"}, 32'(ex_ld), 0);
        check({tag, "_mem_dst"}, 32'(mem_dst_addr), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 2; i++) inflight[i] = '{0, 0, 0, '0};
        m_cnt = 0; exp_stall = 0; exp_cnt_now = 0; exp_mem_we = 0; exp_mem_dst = '0;
    endtask

    // Monitor: per-cycle status checks plus scoreboard pop on every valid EX.
    always @(negedge clk) begin
        if (!rst) begin
            check("stall_id", 32'(stall_id), 32'(exp_stall));
            check("stall_cnt", 32'(stall_cnt), 32'(exp_cnt_now));
            check("mem_we", 32'(mem_we), 32'(exp_mem_we));
            if (exp_mem_we) check("mem_dst", 32'(mem_dst_addr), 32'(exp_mem_dst));
            if (ex_vld) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ex_vld: got ex_vld=1 expected no instruction at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ex_opA", 32'(ex_opA), 32'(e.a));
                    check("ex_opB", 32'(ex_opB), 32'(e.b));
                    check("ex_dst", 32'(ex_dst_addr), 32'(e.dst));
                    check("ex_we", 32'(ex_we), 32'(e.we));
                    check("ex_ld", 32'(ex_ld), 32'(e.ld));
                end
            end
        end
    end

    initial begin
        stim_t s;
        bit    held;
        model_reset();
        #3;
        check_all_zero("reset");

        // EX forwarding
        drive(mk(1, 0, 4'd1, 0, 0, 0, 0));
        s = mk(0, 0, 0, 1, 4'd1, 0, 0); s.rf0 = 16'h0000; s.exr = 16'h0005; drive(s);
        // EX beats MEM on the same register
        drive(mk(1, 0, 4'd2, 0, 0, 0, 0));
        drive(mk(1, 0, 4'd2, 0, 0, 0, 0));
        s = mk(0, 0, 0, 0, 0, 1, 4'd2); s.memr = 16'h1111; s.exr = 16'h2222; drive(s);
        // MEM only
        drive(mk(1, 0, 4'd2, 0, 0, 0, 0));
        drive(mk(1, 0, 4'd5, 0, 0, 0, 0));
        s = mk(0, 0, 0, 0, 0, 1, 4'd2); s.memr = 16'h1111; s.exr = 16'h2222; drive(s);
        // Load-use: one stall, then forwarded from MEM
        drive(mk(1, 1, 4'd3, 0, 0, 0, 0));
        s = mk(0, 0, 0, 1, 4'd3, 0, 0); drive(s);
        s.memr = 16'hBEEF; drive(s);
        // R0 never forwarded
        s = mk(1, 0, 4'd0, 0, 0, 0, 0); drive(s);
        s = mk(0, 0, 0, 1, 4'd0, 1, 4'd0); s.exr = 16'hFFFF; drive(s);
        // Unused source ignores a matching load
        drive(mk(1, 1, 4'd4, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 4'd4, 0, 0));
        // Flush overrides load-use
        drive(mk(1, 1, 4'd6, 0, 0, 0, 0));
        s = mk(0, 0, 0, 1, 4'd6, 1, 4'd6); s.flush = 1; drive(s);
        // Same register on both sources from EX
        drive(mk(1, 0, 4'd7, 0, 0, 0, 0));
        s = mk(0, 0, 0, 1, 4'd7, 1, 4'd7); s.exr = 16'hA5A5; drive(s);

        held = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                // async reset between edges, then first instruction uses RF data
                #2;
                rst = 1'b1;
                #1;
                check_all_zero("midreset");
                model_reset();
                held = 0;
                s = mk(0, 0, 0, 1, 4'd1, 1, 4'd2); s.rf0 = 16'h1234; s.rf1 = 16'h5678;
                drive(s);
            end
            if (held) begin
                s.exr   = 16'($urandom);
                s.memr  = 16'($urandom);
                s.flush = ($urandom_range(0, 9) == 0);
            end else begin
                s = rnd();
            end
            drive(s);
            held = exp_stall;
        end

        for (int n = 0; n < 3; n++) begin
            s = mk(0, 0, 0, 0, 0, 0, 0); s.vld = 0; drive(s);
        end
        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
